// File: rtl/adder_tree_pkg.sv
// Shared types and widths for the adder tree and its downstream stages.
package adder_tree_pkg;

  localparam int ADDER_WIDTH = 4;
  localparam int TREE_LEVELS = 3;

  // Width of one tree result: each level adds one carry bit.
  function automatic int sum_width(input int adder_w, input int levels);
    return adder_w + levels;
  endfunction

  localparam int SUM_WIDTH = sum_width(ADDER_WIDTH, TREE_LEVELS);

  typedef enum logic [0:0] {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/adder_tree_accumulator_if.sv
// Stream interface of the block accumulator: sample input, block-result output, clear.
interface adder_tree_accumulator_if #(
  parameter int SUM_WIDTH   = adder_tree_pkg::SUM_WIDTH,
  parameter int LOG2_FRAMES = 2,
  parameter int CNT_WIDTH   = 16
);

  logic                             clear;
  logic                             in_valid;
  logic [SUM_WIDTH-1:0]             in_sum;
  logic                             in_ready;
  logic                             out_valid;
  logic                             out_ready;
  logic [SUM_WIDTH+LOG2_FRAMES-1:0] out_total;
  logic [SUM_WIDTH-1:0]             out_mean;
  logic [CNT_WIDTH-1:0]             frame_count;

  modport master (
    output clear, in_valid, in_sum, out_ready,
    input  in_ready, out_valid, out_total, out_mean, frame_count
  );

  modport slave (
    input  clear, in_valid, in_sum, out_ready,
    output in_ready, out_valid, out_total, out_mean, frame_count
  );

endinterface

// File: rtl/adder_tree_result_buf.sv
// One-deep valid/ready holding register for completed block results.
// Supports load, drain, and simultaneous load+drain without a bubble.
module adder_tree_result_buf
  import adder_tree_pkg::*;
#(
  parameter int TOTAL_W = 9,
  parameter int MEAN_W  = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               drain_ready,
  input  logic [TOTAL_W-1:0] total_d,
  input  logic [MEAN_W-1:0]  mean_d,
  output logic               valid,
  output logic [TOTAL_W-1:0] total_q,
  output logic [MEAN_W-1:0]  mean_q
);

  out_state_e state_q;
  out_state_e state_d;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OUT_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a load always leaves the buffer full; a drain alone empties it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      OUT_EMPTY: if (load) state_d = OUT_FULL;
      OUT_FULL: begin
        if (load) begin
          state_d = OUT_FULL;
        end else if (drain_ready) begin
          state_d = OUT_EMPTY;
        end
      end
      default: state_d = OUT_EMPTY;
    endcase
  end

  // Output decode: the buffer is presented whenever it holds a result.
  always_comb begin
    valid = (state_q == OUT_FULL);
  end

  // Result payload: loaded on completion, otherwise held stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      total_q <= '0;
      mean_q  <= '0;
    end else if (load) begin
      total_q <= total_d;
      mean_q  <= mean_d;
    end
  end

endmodule

// File: rtl/adder_tree_accumulator.sv
// Block accumulator behind the adder tree: sums 2**LOG2_FRAMES accepted tree
// results into one exact total, publishes total and truncated mean through a
// one-deep result buffer, and counts completed blocks.
module adder_tree_accumulator #(
  parameter int ADDER_WIDTH = adder_tree_pkg::ADDER_WIDTH,
  parameter int TREE_LEVELS = adder_tree_pkg::TREE_LEVELS,
  parameter int LOG2_FRAMES = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  adder_tree_accumulator_if.slave  bus
);

  import adder_tree_pkg::*;

  localparam int SUM_W   = sum_width(ADDER_WIDTH, TREE_LEVELS);
  localparam int TOTAL_W = SUM_W + LOG2_FRAMES;
  // Block size is a power of two, so the last sample index is all ones.
  localparam logic [LOG2_FRAMES-1:0] CNT_LAST = '1;

  // Mean is the total divided by the block size, truncating toward zero.
  function automatic logic [SUM_W-1:0] block_mean(input logic [TOTAL_W-1:0] total);
    return total[TOTAL_W-1:LOG2_FRAMES];
  endfunction

  logic [TOTAL_W-1:0]     acc_p0;
  logic [TOTAL_W-1:0]     sum_p0;
  logic [LOG2_FRAMES-1:0] cnt_p0;
  logic                   block_last;
  logic                   accept;
  logic                   complete;
  logic                   out_valid_p1;
  logic [CNT_WIDTH-1:0]   frame_count_q;

  // Stage 0: running sum of the current block and handshake decode.
  always_comb begin
    sum_p0        = acc_p0 + {{LOG2_FRAMES{1'b0}}, bus.in_sum};
    block_last    = (cnt_p0 == CNT_LAST);
    bus.in_ready  = !(block_last && out_valid_p1 && !bus.out_ready);
    accept        = bus.in_valid && bus.in_ready;
    // A clear on the same cycle drops the sample, so it cannot complete a block.
    complete      = accept && block_last && !bus.clear;
  end

  // Accumulator and sample counter; clear discards the partial block.
  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      acc_p0 <= '0;
      cnt_p0 <= '0;
    end else if (accept) begin
      if (block_last) begin
        acc_p0 <= '0;
        cnt_p0 <= '0;
      end else begin
        acc_p0 <= sum_p0;
        cnt_p0 <= cnt_p0 + 1'b1;
      end
    end
  end

  // Completed-block counter, wraps silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_count_q <= '0;
    end else if (complete) begin
      frame_count_q <= frame_count_q + 1'b1;
    end
  end

  // Stage 1: result buffer holds the finished block until the consumer takes it.
  adder_tree_result_buf #(
    .TOTAL_W (TOTAL_W),
    .MEAN_W  (SUM_W)
  ) u_result_buf (
    .clk         (clk),
    .rst         (rst),
    .load        (complete),
    .drain_ready (bus.out_ready),
    .total_d     (sum_p0),
    .mean_d      (block_mean(sum_p0)),
    .valid       (out_valid_p1),
    .total_q     (bus.out_total),
    .mean_q      (bus.out_mean)
  );

  assign bus.out_valid   = out_valid_p1;
  assign bus.frame_count = frame_count_q;

endmodule
